gray_wptr_gen: RTL and testbench

Write-side pointer generator for the dual-clock FIFOs in the Ethernet datapath. It is the binary-to-Gray counterpart of the Gray-to-binary converter used on the read side.
- Keeps a binary write pointer.
- Publishes a registered, glitch-free Gray-coded copy of the pointer for the read clock domain to synchronise.
- Computes a registered full flag against the read pointer after it has been synchronised into this domain.
- Sits in the write clock domain, between the write-request logic and the FIFO RAM and synchroniser.

---
 rtl/gray_wptr_gen_if.sv | 20 ++
 rtl/gray_wptr_gen.sv | 74 +++++++
 tb/tb_gray_wptr_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gray_wptr_gen_if.sv
// rtl/gray_wptr_gen_if.sv - request/status bundle for gray_wptr_gen; almost_full present only with GRAY_WPTR_ALMOST_FULL_EN
interface gray_wptr_gen_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  clr;
  logic                  inc;
  logic [ADDR_WIDTH:0]   rptr_gray_sync;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  full;
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  logic                  almost_full;

  modport master (output clr, inc, rptr_gray_sync, input waddr, wptr_gray, full, almost_full);
  modport slave  (input clr, inc, rptr_gray_sync, output waddr, wptr_gray, full, almost_full);
`else
  modport master (output clr, inc, rptr_gray_sync, input waddr, wptr_gray, full);
  modport slave  (input clr, inc, rptr_gray_sync, output waddr, wptr_gray, full);
`endif
endinterface

// File: rtl/gray_wptr_gen.sv
// rtl/gray_wptr_gen.sv - write-domain binary/Gray pointer with registered full flag
// Optional almost_full output enabled by defining GRAY_WPTR_ALMOST_FULL_EN.
module gray_wptr_gen #(
  parameter int ADDR_WIDTH = 4
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  , parameter int AF_THRESH = 2**ADDR_WIDTH - 2
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_wptr_gen_if.slave wp
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr_gray;
  logic          r_full;

  logic          w_inc_eff;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_full_gray;

  assign w_inc_eff   = wp.inc & ~r_full;
  assign w_wbin_next = wp.clr ? '0 : r_wbin + {{ADDR_WIDTH{1'b0}}, w_inc_eff};
  assign w_gray_next = w_wbin_next ^ (w_wbin_next >> 1);
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign w_full_gray = {~wp.rptr_gray_sync[PW-1:PW-2], wp.rptr_gray_sync[PW-3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin      <= '0;
      r_wptr_gray <= '0;
      r_full      <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      r_wptr_gray <= w_gray_next;
      r_full      <= (w_gray_next == w_full_gray);
    end
  end

  assign wp.waddr     = r_wbin[ADDR_WIDTH-1:0];
  assign wp.wptr_gray = r_wptr_gray;
  assign wp.full      = r_full;

`ifdef GRAY_WPTR_ALMOST_FULL_EN
  localparam logic [PW:0] AF_T = (PW+1)'(AF_THRESH);

  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_level_next;
  logic          r_almost_full;

  always_comb begin
    w_rbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_rbin[i] = ^(wp.rptr_gray_sync >> i);
    end
  end

  assign w_level_next = w_wbin_next - w_rbin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= ~wp.clr & ({1'b0, w_level_next} >= AF_T);
    end
  end

  assign wp.almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_gray_wptr_gen.sv
// tb/tb_gray_wptr_gen.sv - self-checking bench for gray_wptr_gen with an occupancy-count reference model
module tb_gray_wptr_gen;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << (AW + 1);
  localparam int AF    = 3;

  logic clk;
  logic rst_n;

  gray_wptr_gen_if #(.ADDR_WIDTH(AW)) wp ();

  gray_wptr_gen #(
    .ADDR_WIDTH(AW)
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    , .AF_THRESH(AF)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wp    (wp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: count of accepted writes and the read count presented on rptr.
  int m_wr   = 0;
  bit m_full = 1'b0;
  bit m_af   = 1'b0;

  function automatic logic [AW:0] bin2gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int popcount(input logic [AW:0] v);
    int c;
    c = 0;
    for (int i = 0; i <= AW; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic cycle(input bit inc, input bit clr, input int rd);
    int lvl;
    wp.inc            = inc;
    wp.clr            = clr;
    wp.rptr_gray_sync = bin2gray(rd);
    @(posedge clk);
    if (clr) m_wr = 0;
    else if (inc && !m_full) m_wr = (m_wr + 1) % PMOD;
    lvl    = (m_wr - rd + PMOD) % PMOD;
    m_full = (lvl == DEPTH);
    m_af   = !clr && (lvl >= AF);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wp.inc = 1'b0; wp.clr = 1'b0; wp.rptr_gray_sync = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (wp.waddr !== 2'd0) begin n_err++; $display("FAIL reset_waddr got %0d want 0", wp.waddr); end
    n_cmp++; if (wp.wptr_gray !== 3'd0) begin n_err++; $display("FAIL reset_gray got %b want 000", wp.wptr_gray); end
    n_cmp++; if (wp.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", wp.full); end
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    n_cmp++; if (wp.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got %b want 0", wp.almost_full); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_wr = 0; m_full = 1'b0; m_af = 1'b0;
  endtask

  task automatic test_fill();
    logic [AW:0] exp_g [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b110, 3'b110};
    int          exp_a [6] = '{1, 2, 3, 0, 0, 0};
    bit          exp_f [6] = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 0);
      n_cmp++; if (wp.wptr_gray !== exp_g[i]) begin n_err++; $display("FAIL fill_gray[%0d] got %b want %b", i, wp.wptr_gray, exp_g[i]); end
      n_cmp++; if (int'(wp.waddr) !== exp_a[i]) begin n_err++; $display("FAIL fill_waddr[%0d] got %0d want %0d", i, wp.waddr, exp_a[i]); end
      n_cmp++; if (wp.full !== exp_f[i]) begin n_err++; $display("FAIL fill_full[%0d] got %b want %b", i, wp.full, exp_f[i]); end
    end
  endtask

  task automatic test_drain_refill();
    cycle(1'b0, 1'b0, 1);
    n_cmp++; if (wp.full !== 1'b0) begin n_err++; $display("FAIL drain_full got %b want 0", wp.full); end
    n_cmp++; if (wp.wptr_gray !== 3'b110) begin n_err++; $display("FAIL drain_gray got %b want 110", wp.wptr_gray); end
    cycle(1'b1, 1'b0, 1);
    n_cmp++; if (wp.wptr_gray !== 3'b111) begin n_err++; $display("FAIL refill_gray got %b want 111", wp.wptr_gray); end
    n_cmp++; if (wp.full !== 1'b1) begin n_err++; $display("FAIL refill_full got %b want 1", wp.full); end
  endtask

  task automatic test_wrap();
    logic [AW:0] exp_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [AW:0] prev;
    cycle(1'b0, 1'b1, 0);
    prev = wp.wptr_gray;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, m_wr);
      n_cmp++; if (wp.wptr_gray !== exp_g[i]) begin n_err++; $display("FAIL wrap_gray[%0d] got %b want %b", i, wp.wptr_gray, exp_g[i]); end
      n_cmp++; if (popcount(prev ^ wp.wptr_gray) != 1) begin n_err++; $display("FAIL wrap_onebit[%0d] got %b->%b want one toggle", i, prev, wp.wptr_gray); end
      n_cmp++; if (wp.full !== 1'b0) begin n_err++; $display("FAIL wrap_full[%0d] got %b want 0", i, wp.full); end
      prev = wp.wptr_gray;
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1, 0);
    repeat (3) cycle(1'b1, 1'b0, 0);
    n_cmp++; if (wp.wptr_gray !== 3'b010) begin n_err++; $display("FAIL arst_pre_gray got %b want 010", wp.wptr_gray); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (wp.wptr_gray !== 3'd0) begin n_err++; $display("FAIL arst_gray got %b want 000", wp.wptr_gray); end
    n_cmp++; if (wp.waddr !== 2'd0) begin n_err++; $display("FAIL arst_waddr got %0d want 0", wp.waddr); end
    n_cmp++; if (wp.full !== 1'b0) begin n_err++; $display("FAIL arst_full got %b want 0", wp.full); end
    @(posedge clk); #1;
    n_cmp++; if (wp.wptr_gray !== 3'd0) begin n_err++; $display("FAIL arst_hold_gray got %b want 000", wp.wptr_gray); end
    wp.inc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_wr = 0; m_full = 1'b0; m_af = 1'b0;
    cycle(1'b1, 1'b0, 0);
    n_cmp++; if (wp.wptr_gray !== 3'b001) begin n_err++; $display("FAIL arst_first_gray got %b want 001", wp.wptr_gray); end
  endtask

  task automatic test_clear();
    cycle(1'b0, 1'b1, 0);
    repeat (3) cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 4);
    n_cmp++; if (wp.wptr_gray !== 3'd0) begin n_err++; $display("FAIL clr_gray got %b want 000", wp.wptr_gray); end
    n_cmp++; if (wp.waddr !== 2'd0) begin n_err++; $display("FAIL clr_waddr got %0d want 0", wp.waddr); end
    n_cmp++; if (wp.full !== 1'b1) begin n_err++; $display("FAIL clr_full_rd4 got %b want 1", wp.full); end
    cycle(1'b0, 1'b1, 0);
    n_cmp++; if (wp.full !== 1'b0) begin n_err++; $display("FAIL clr_full_rd0 got %b want 0", wp.full); end
  endtask

`ifdef GRAY_WPTR_ALMOST_FULL_EN
  task automatic test_almost_full();
    cycle(1'b0, 1'b1, 0);
    repeat (2) cycle(1'b1, 1'b0, 0);
    n_cmp++; if (wp.almost_full !== 1'b0) begin n_err++; $display("FAIL af_two got %b want 0", wp.almost_full); end
    cycle(1'b1, 1'b0, 0);
    n_cmp++; if (wp.almost_full !== 1'b1) begin n_err++; $display("FAIL af_three got %b want 1", wp.almost_full); end
    cycle(1'b0, 1'b0, 1);
    n_cmp++; if (wp.almost_full !== 1'b0) begin n_err++; $display("FAIL af_drop got %b want 0", wp.almost_full); end
  endtask
`endif

  task automatic test_random();
    int          rd;
    bit          inc, clr;
    logic [AW:0] prev;
    cycle(1'b0, 1'b1, 0);
    rd   = 0;
    prev = wp.wptr_gray;
    for (int i = 0; i < 400; i++) begin
      inc = ($urandom_range(0, 99) < 65);
      clr = ($urandom_range(0, 99) < 3);
      if (((m_wr - rd + PMOD) % PMOD) > 0 && $urandom_range(0, 1) == 1) rd = (rd + 1) % PMOD;
      cycle(inc, clr, rd);
      n_cmp++; if (wp.wptr_gray !== bin2gray(m_wr)) begin n_err++; $display("FAIL rnd_gray[%0d] got %b want %b", i, wp.wptr_gray, bin2gray(m_wr)); end
      n_cmp++; if (int'(wp.waddr) !== (m_wr % DEPTH)) begin n_err++; $display("FAIL rnd_waddr[%0d] got %0d want %0d", i, wp.waddr, m_wr % DEPTH); end
      n_cmp++; if (wp.full !== m_full) begin n_err++; $display("FAIL rnd_full[%0d] got %b want %b", i, wp.full, m_full); end
`ifdef GRAY_WPTR_ALMOST_FULL_EN
      n_cmp++; if (wp.almost_full !== m_af) begin n_err++; $display("FAIL rnd_af[%0d] got %b want %b", i, wp.almost_full, m_af); end
`endif
      if (!clr) begin
        n_cmp++; if (popcount(prev ^ wp.wptr_gray) > 1) begin n_err++; $display("FAIL rnd_onebit[%0d] got %b->%b want <=1 toggle", i, prev, wp.wptr_gray); end
      end
      prev = wp.wptr_gray;
      if (clr) rd = 0;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_refill();
    test_wrap();
    test_async_reset();
    test_clear();
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    test_almost_full();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
